// File: rtl/ysyx_220053_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_220053_ctrl_fsm : multi-cycle FETCH/DECODE/MEM/WB sequencer, rev 1.0  |
// +----------------------------------------------------------------------------+
module ysyx_220053_ctrl_fsm #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  input  logic             dec_legal,
  input  logic             dec_is_ebreak,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_wen,
  input  logic [4:0]       dec_rd,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_wen,
  output logic             pc_we,
  output logic             halted,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  state_t             state, state_nx;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               st_q;
  logic               wen_q;
  logic [1:0]         code_q, code_nx;
  logic [CNT_W-1:0]   instret_q;
  logic               timed_out;

  assign timed_out = (TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    ir_we    = 1'b0;
    case (state)
      IDLE:   if (start) state_nx = FETCH;
      FETCH: begin
        // An ack on the last allowed cycle beats the timeout.
        if (imem_ack) begin
          ir_we    = 1'b1;
          state_nx = DECODE;
        end else if (timed_out) begin
          state_nx = HALT;
          code_nx  = 2'd3;
        end
      end
      DECODE: begin
        if (!dec_legal) begin
          state_nx = HALT;
          code_nx  = 2'd2;
        end else if (dec_is_ebreak) begin
          state_nx = HALT;
          code_nx  = 2'd1;
        end else if (dec_is_load || dec_is_store) begin
          state_nx = MEM;
        end else begin
          state_nx = WB;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          state_nx = WB;
        end else if (timed_out) begin
          state_nx = HALT;
          code_nx  = 2'd3;
        end
      end
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      st_q      <= 1'b0;
      wen_q     <= 1'b0;
      code_q    <= 2'd0;
      instret_q <= '0;
    end else begin
      state  <= state_nx;
      code_q <= code_nx;
      // Counter is zero whenever a FETCH/MEM stay is not continuing, so entry starts from zero.
      if ((state == FETCH || state == MEM) && state_nx == state)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
      if (state == DECODE) begin
        st_q  <= dec_is_store;
        wen_q <= dec_wen && (dec_rd != 5'd0) && !dec_is_store;
      end
      if (state == WB)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign imem_req  = (state == FETCH);
  assign dmem_req  = (state == MEM);
  assign dmem_we   = (state == MEM) && st_q;
  assign pc_we     = (state == WB);
  assign rf_wen    = (state == WB) && wen_q;
  assign halted    = (state == HALT);
  assign halt_code = code_q;
  assign instret   = instret_q;
  assign state_o   = state;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220053_ctrl_fsm.sv
`default_nettype none
// Randomised bench for ysyx_220053_ctrl_fsm; expected strobes come from per-instruction descriptions.
module tb_ysyx_220053_ctrl_fsm;
  localparam int TO = 8;
  localparam int CW = 4;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EBREAK = 3, K_ILLEGAL = 4;

  logic          clk = 1'b0;
  logic          rst, start, imem_ack, dmem_ack;
  logic          dec_legal, dec_is_ebreak, dec_is_load, dec_is_store, dec_wen;
  logic [4:0]    dec_rd;
  logic          imem_req, ir_we, dmem_req, dmem_we, rf_wen, pc_we, halted;
  logic [1:0]    halt_code;
  logic [CW-1:0] instret;
  logic [2:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int retired  = 0;

  wire [9:0] obs = {imem_req, ir_we, dmem_req, dmem_we, rf_wen, pc_we, halted, state_o};

  ysyx_220053_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .dec_legal(dec_legal), .dec_is_ebreak(dec_is_ebreak), .dec_is_load(dec_is_load),
    .dec_is_store(dec_is_store), .dec_wen(dec_wen), .dec_rd(dec_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_wen(rf_wen), .pc_we(pc_we), .halted(halted), .halt_code(halt_code),
    .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_legal = 1'b0; dec_is_ebreak = 1'b0; dec_is_load = 1'b0;
    dec_is_store = 1'b0; dec_wen = 1'b0; dec_rd = 5'd0;
    step();
    step();
    rst = 1'b0;
    retired = 0;
  endtask

  task automatic begin_run(input string tag);
    logic [9:0] exp;
    do_reset();
    start = 1'b1;
    #1;
    exp = {7'b0, 3'd0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s idle: got %b want %b", tag, obs, exp); end
    step();
    start = 1'b0;
  endtask

  // Walks one instruction from FETCH; fd/md are the number of ack-less cycles before ack.
  task automatic run_instr(input int kind, input int fd, input int md, input logic wen,
                           input logic [4:0] rd, input string tag);
    logic [9:0] exp;
    logic       store;
    store = (kind == K_STORE);
    for (int i = 0; i < TO; i++) begin
      imem_ack = (i == fd);
      start = 1'($urandom_range(0, 1));
      dec_legal = 1'($urandom_range(0, 1));
      dec_is_ebreak = 1'($urandom_range(0, 1));
      #1;
      exp = {1'b1, (i == fd), 5'b0, 3'd1};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s fetch%0d: got %b want %b", tag, i, obs, exp); end
      step();
      if (i == fd) break;
    end
    imem_ack = 1'b0;
    start = 1'b0;
    if (fd >= TO) begin
      #1;
      exp = {6'b0, 1'b1, 3'd5};
      n_checks++;
      if (obs !== exp || halt_code !== 2'd3 || instret !== CW'(retired)) begin
        n_fail++;
        $display("FAIL %s fetch_timeout: got %b code %0d ret %0d want %b code 3 ret %0d",
                 tag, obs, halt_code, instret, exp, CW'(retired));
      end
      return;
    end
    dec_legal     = (kind != K_ILLEGAL);
    dec_is_ebreak = (kind == K_EBREAK) || (kind == K_ILLEGAL && $urandom_range(0, 1) == 1);
    dec_is_load   = (kind == K_LOAD);
    dec_is_store  = store;
    dec_wen       = wen;
    dec_rd        = rd;
    #1;
    exp = {7'b0, 3'd2};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s decode: got %b want %b", tag, obs, exp); end
    step();
    if (kind == K_EBREAK || kind == K_ILLEGAL) begin
      exp = {6'b0, 1'b1, 3'd5};
      n_checks++;
      if (obs !== exp || halt_code !== ((kind == K_EBREAK) ? 2'd1 : 2'd2) || instret !== CW'(retired)) begin
        n_fail++;
        $display("FAIL %s halt: got %b code %0d ret %0d want %b code %0d ret %0d", tag, obs, halt_code,
                 instret, exp, (kind == K_EBREAK) ? 1 : 2, CW'(retired));
      end
      return;
    end
    if (kind == K_LOAD || kind == K_STORE) begin
      for (int j = 0; j < TO; j++) begin
        dmem_ack = (j == md);
        #1;
        exp = {2'b0, 1'b1, store, 3'b0, 3'd3};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s mem%0d: got %b want %b", tag, j, obs, exp); end
        step();
        if (j == md) break;
      end
      dmem_ack = 1'b0;
      if (md >= TO) begin
        exp = {6'b0, 1'b1, 3'd5};
        n_checks++;
        if (obs !== exp || halt_code !== 2'd3) begin
          n_fail++;
          $display("FAIL %s mem_timeout: got %b code %0d want %b code 3", tag, obs, halt_code, exp);
        end
        return;
      end
    end
    #1;
    exp = {4'b0, (wen && rd != 5'd0 && !store), 1'b1, 1'b0, 3'd4};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s wb: got %b want %b", tag, obs, exp); end
    step();
    retired++;
    n_checks++;
    if (instret !== CW'(retired)) begin
      n_fail++;
      $display("FAIL %s instret: got %0d want %0d", tag, instret, CW'(retired));
    end
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    do_reset();
    exp = {7'b0, 3'd0};
    n_checks++;
    if (obs !== exp || instret !== '0 || halt_code !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: got %b ret %0d code %0d want %b ret 0 code 0", obs, instret, halt_code, exp);
    end
  endtask

  task automatic test_addi();
    begin_run("addi");
    run_instr(K_ALU, 0, 0, 1'b1, 5'd5, "addi");
  endtask

  task automatic test_load_delay();
    run_instr(K_LOAD, 0, 4, 1'b1, 5'd7, "load");
  endtask

  task automatic test_store_x0();
    run_instr(K_STORE, 1, 0, 1'b1, 5'd3, "store");
    run_instr(K_ALU, 0, 0, 1'b1, 5'd0, "addi_x0");
  endtask

  task automatic test_ebreak_halt();
    logic [9:0] exp;
    begin_run("ebreak");
    for (int k = 0; k < 3; k++) run_instr(k % 3, 0, 1, 1'b1, 5'd9, "ebreak_pre");
    run_instr(K_EBREAK, 0, 0, 1'b0, 5'd0, "ebreak");
    for (int k = 0; k < 4; k++) begin
      start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
      step();
      exp = {6'b0, 1'b1, 3'd5};
      n_checks++;
      if (obs !== exp || halt_code !== 2'd1 || instret !== CW'(3)) begin
        n_fail++;
        $display("FAIL halt_sticky: got %b code %0d ret %0d want %b code 1 ret 3", obs, halt_code, instret, exp);
      end
    end
    start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    begin_run("to_fetch");
    run_instr(K_ALU, TO, 0, 1'b0, 5'd0, "to_fetch");
    begin_run("to_edge");
    run_instr(K_ALU, TO - 1, 0, 1'b1, 5'd1, "to_edge");
    run_instr(K_LOAD, 0, TO - 1, 1'b1, 5'd2, "to_mem_edge");
    run_instr(K_STORE, 0, TO, 1'b0, 5'd0, "to_mem");
    begin_run("illegal");
    run_instr(K_ILLEGAL, 2, 0, 1'b1, 5'd4, "illegal");
  endtask

  task automatic test_rst_mid();
    logic [9:0] exp;
    begin_run("rst_mid");
    run_instr(K_ALU, 0, 0, 1'b1, 5'd6, "rst_mid_pre");
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; dec_legal = 1'b1; dec_is_ebreak = 1'b0; dec_is_load = 1'b1; dec_is_store = 1'b0;
    step();
    step();
    n_checks++;
    if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_inmem: got dmem_req %b want 1", dmem_req); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp = {7'b0, 3'd0};
    n_checks++;
    if (obs !== exp || instret !== '0 || halt_code !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got %b ret %0d code %0d want %b ret 0 code 0", obs, instret, halt_code, exp);
    end
  endtask

  task automatic test_random();
    int kind;
    begin_run("random");
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      run_instr(kind, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), "random");
    end
    kind = $urandom_range(3, 4);
    run_instr(kind, $urandom_range(0, TO - 1), 0, 1'b1, 5'd1, "random_end");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_delay();
    test_store_x0();
    test_ebreak_halt();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
